// File: rtl/e203_nice_arb_pkg.sv
// Shared types and constants for the two-master NICE arbiter.
// The optional E203_NICE_ARB_FIXED_PRIO_EN build makes master 0 win every contention.
package e203_nice_arb_pkg;

    localparam int NICE_XLEN              = 32;
    localparam int NICE_ARB_DEFAULT_DEPTH = 4;

    typedef logic [0:0] nice_mid_t;

    localparam nice_mid_t MID_M0 = 1'b0;
    localparam nice_mid_t MID_M1 = 1'b1;

    typedef struct packed {
        logic [NICE_XLEN-1:0] instr;
        logic [NICE_XLEN-1:0] rs1;
        logic [NICE_XLEN-1:0] rs2;
    } nice_req_t;

    function automatic nice_mid_t other_mid(input nice_mid_t mid);
        return ~mid;
    endfunction

endpackage

// File: rtl/e203_nice_arb_idfifo.sv
// In-order tracking FIFO holding the master ID of each accepted request.
// Pointers carry an extra MSB so full and empty are told apart without a counter.
module e203_nice_arb_idfifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  T            push_data,
    input  logic        pop,
    output T            head,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: entries are only read between a push and its pop.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/e203_nice_arb.sv
// Shares one NICE coprocessor port between two masters and steers responses back in order.
// Define E203_NICE_ARB_FIXED_PRIO_EN for fixed master-0 priority instead of round-robin.
module e203_nice_arb
    import e203_nice_arb_pkg::*;
#(
    parameter int  OSTD_DEPTH = NICE_ARB_DEFAULT_DEPTH,
    localparam int CW         = $clog2(OSTD_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 m0_req_valid,
    output logic                 m0_req_ready,
    input  logic [NICE_XLEN-1:0] m0_req_instr,
    input  logic [NICE_XLEN-1:0] m0_req_rs1,
    input  logic [NICE_XLEN-1:0] m0_req_rs2,
    output logic                 m0_rsp_valid,
    input  logic                 m0_rsp_ready,

    input  logic                 m1_req_valid,
    output logic                 m1_req_ready,
    input  logic [NICE_XLEN-1:0] m1_req_instr,
    input  logic [NICE_XLEN-1:0] m1_req_rs1,
    input  logic [NICE_XLEN-1:0] m1_req_rs2,
    output logic                 m1_rsp_valid,
    input  logic                 m1_rsp_ready,

    output logic [NICE_XLEN-1:0] m_rsp_dat,
    output logic                 m_rsp_err,

    output logic                 nice_req_valid,
    input  logic                 nice_req_ready,
    output logic [NICE_XLEN-1:0] nice_req_instr,
    output logic [NICE_XLEN-1:0] nice_req_rs1,
    output logic [NICE_XLEN-1:0] nice_req_rs2,

    input  logic                 nice_rsp_multicyc_valid,
    output logic                 nice_rsp_multicyc_ready,
    input  logic [NICE_XLEN-1:0] nice_rsp_multicyc_dat,
    input  logic                 nice_rsp_multicyc_err,

    output logic [CW-1:0]        ostd_cnt,
    output logic                 rsp_orphan
);

    nice_req_t m0_req;
    nice_req_t m1_req;
    nice_req_t sel_req;

    nice_mid_t grant;
    nice_mid_t contend_pick;
    nice_mid_t lock_id;
    nice_mid_t head;
    logic      lock_vld;
    logic      sel_valid;
    logic      accept;
    logic      pop;
    logic      full;
    logic      empty;
    logic      rsp_sel_ready;

    assign m0_req = '{instr: m0_req_instr, rs1: m0_req_rs1, rs2: m0_req_rs2};
    assign m1_req = '{instr: m1_req_instr, rs1: m1_req_rs1, rs2: m1_req_rs2};

`ifdef E203_NICE_ARB_FIXED_PRIO_EN
    assign contend_pick = MID_M0;
`else
    nice_mid_t rr_ptr;

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= MID_M0;
        else if (accept)
            rr_ptr <= other_mid(grant);
    end

    assign contend_pick = rr_ptr;
`endif

    always_comb begin
        grant = MID_M0;
        if (lock_vld)
            grant = lock_id;
        else if (m0_req_valid && m1_req_valid)
            grant = contend_pick;
        else if (m1_req_valid)
            grant = MID_M1;
    end

    assign sel_valid = (grant == MID_M1) ? m1_req_valid : m0_req_valid;
    assign sel_req   = (grant == MID_M1) ? m1_req : m0_req;

    // Full is the registered occupancy, so a same-cycle pop cannot make room for a push.
    assign nice_req_valid = !rst && !full && sel_valid;
    assign nice_req_instr = sel_req.instr;
    assign nice_req_rs1   = sel_req.rs1;
    assign nice_req_rs2   = sel_req.rs2;
    assign accept         = nice_req_valid && nice_req_ready;

    assign m0_req_ready = !rst && sel_valid && (grant == MID_M0) && nice_req_ready && !full;
    assign m1_req_ready = !rst && sel_valid && (grant == MID_M1) && nice_req_ready && !full;

    // A presented-but-unaccepted request pins the grant; a master that withdraws releases it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld <= 1'b0;
            lock_id  <= MID_M0;
        end else if (accept || !sel_valid) begin
            lock_vld <= 1'b0;
        end else if (nice_req_valid) begin
            lock_vld <= 1'b1;
            lock_id  <= grant;
        end
    end

    e203_nice_arb_idfifo #(
        .DEPTH (OSTD_DEPTH),
        .T     (nice_mid_t)
    ) u_idfifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (grant),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (ostd_cnt)
    );

    assign rsp_sel_ready           = (head == MID_M1) ? m1_rsp_ready : m0_rsp_ready;
    assign nice_rsp_multicyc_ready = !rst && !empty && rsp_sel_ready;
    assign pop                     = nice_rsp_multicyc_valid && nice_rsp_multicyc_ready;

    assign m0_rsp_valid = !rst && nice_rsp_multicyc_valid && !empty && (head == MID_M0);
    assign m1_rsp_valid = !rst && nice_rsp_multicyc_valid && !empty && (head == MID_M1);
    assign m_rsp_dat    = nice_rsp_multicyc_dat;
    assign m_rsp_err    = nice_rsp_multicyc_err;

    always_ff @(posedge clk) begin
        if (rst)
            rsp_orphan <= 1'b0;
        else if (nice_rsp_multicyc_valid && empty)
            rsp_orphan <= 1'b1;
    end

endmodule

// File: tb/tb_e203_nice_arb.sv
// Directed self-checking bench for e203_nice_arb; expectations follow E203_NICE_ARB_FIXED_PRIO_EN.
module tb_e203_nice_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req_valid = 0, m1_req_valid = 0;
    logic        m0_req_ready, m1_req_ready;
    logic [31:0] m0_req_instr = 32'h0000_0100, m0_req_rs1 = 32'h0000_0101, m0_req_rs2 = 32'h0000_0102;
    logic [31:0] m1_req_instr = 32'h0000_0200, m1_req_rs1 = 32'h0000_0201, m1_req_rs2 = 32'h0000_0202;
    logic        m0_rsp_valid, m1_rsp_valid;
    logic        m0_rsp_ready = 0, m1_rsp_ready = 0;
    logic [31:0] m_rsp_dat;
    logic        m_rsp_err;
    logic        nice_req_valid;
    logic        nice_req_ready = 0;
    logic [31:0] nice_req_instr, nice_req_rs1, nice_req_rs2;
    logic        nice_rsp_multicyc_valid = 0;
    logic        nice_rsp_multicyc_ready;
    logic [31:0] nice_rsp_multicyc_dat = 0;
    logic        nice_rsp_multicyc_err = 0;
    logic [2:0]  ostd_cnt;
    logic        rsp_orphan;

    int n_checks = 0;
    int n_fail   = 0;

    e203_nice_arb #(.OSTD_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
        .m0_req_instr(m0_req_instr), .m0_req_rs1(m0_req_rs1), .m0_req_rs2(m0_req_rs2),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
        .m1_req_instr(m1_req_instr), .m1_req_rs1(m1_req_rs1), .m1_req_rs2(m1_req_rs2),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
        .m_rsp_dat(m_rsp_dat), .m_rsp_err(m_rsp_err),
        .nice_req_valid(nice_req_valid), .nice_req_ready(nice_req_ready),
        .nice_req_instr(nice_req_instr), .nice_req_rs1(nice_req_rs1), .nice_req_rs2(nice_req_rs2),
        .nice_rsp_multicyc_valid(nice_rsp_multicyc_valid),
        .nice_rsp_multicyc_ready(nice_rsp_multicyc_ready),
        .nice_rsp_multicyc_dat(nice_rsp_multicyc_dat),
        .nice_rsp_multicyc_err(nice_rsp_multicyc_err),
        .ostd_cnt(ostd_cnt), .rsp_orphan(rsp_orphan)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_req_valid = 0; m1_req_valid = 0; nice_req_ready = 0;
        m0_rsp_ready = 0; m1_rsp_ready = 0; nice_rsp_multicyc_valid = 0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_req_valid = 1; m1_req_valid = 1; nice_req_ready = 1;
        m0_rsp_ready = 1; m1_rsp_ready = 1; nice_rsp_multicyc_valid = 1;
        for (int c = 0; c < 2; c++) begin
            step(); #1;
            n_checks++; if (nice_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid cyc%0d: got %b exp 0", c, nice_req_valid); end
            n_checks++; if ({m0_req_ready, m1_req_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready cyc%0d: got %b exp 00", c, {m0_req_ready, m1_req_ready}); end
            n_checks++; if ({m0_rsp_valid, m1_rsp_valid, nice_rsp_multicyc_ready} !== 3'b000) begin n_fail++; $display("FAIL reset_rsp cyc%0d: got %b exp 000", c, {m0_rsp_valid, m1_rsp_valid, nice_rsp_multicyc_ready}); end
            n_checks++; if (ostd_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt cyc%0d: got %0d exp 0", c, ostd_cnt); end
        end
        rst = 1'b0; nice_rsp_multicyc_valid = 0; nice_req_ready = 0;
        #1;
        n_checks++; if (nice_req_valid !== 1'b1 || nice_req_instr !== 32'h0000_0100) begin n_fail++; $display("FAIL reset_first_grant: got v=%b instr=%h exp v=1 instr=00000100", nice_req_valid, nice_req_instr); end
        n_checks++; if (rsp_orphan !== 1'b0) begin n_fail++; $display("FAIL reset_orphan: got %b exp 0", rsp_orphan); end
    endtask

    task automatic test_contention();
        logic [31:0] exp_instr [4];
`ifdef E203_NICE_ARB_FIXED_PRIO_EN
        exp_instr = '{32'h100, 32'h100, 32'h100, 32'h100};
`else
        exp_instr = '{32'h100, 32'h200, 32'h100, 32'h200};
`endif
        do_reset();
        m0_req_valid = 1; m1_req_valid = 1; nice_req_ready = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++; if (nice_req_valid !== 1'b1 || nice_req_instr !== exp_instr[c]) begin n_fail++; $display("FAIL contention_grant%0d: got v=%b instr=%h exp v=1 instr=%h", c, nice_req_valid, nice_req_instr, exp_instr[c]); end
            step();
        end
        #1;
        n_checks++; if (ostd_cnt !== 3'd4) begin n_fail++; $display("FAIL contention_cnt: got %0d exp 4", ostd_cnt); end
        n_checks++; if ({nice_req_valid, m0_req_ready, m1_req_ready} !== 3'b000) begin n_fail++; $display("FAIL full_stall: got %b exp 000", {nice_req_valid, m0_req_ready, m1_req_ready}); end
    endtask

    // Runs straight after test_contention with four entries outstanding and both masters still valid.
    task automatic test_full();
        nice_rsp_multicyc_valid = 1; m0_rsp_ready = 1; m1_rsp_ready = 1;
        #1;
        n_checks++; if (nice_rsp_multicyc_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready: got %b exp 1", nice_rsp_multicyc_ready); end
        n_checks++; if (nice_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_pop_no_push: got %b exp 0", nice_req_valid); end
        step();
        nice_rsp_multicyc_valid = 0;
        #1;
        n_checks++; if (ostd_cnt !== 3'd3) begin n_fail++; $display("FAIL full_after_pop_cnt: got %0d exp 3", ostd_cnt); end
        n_checks++; if (nice_req_valid !== 1'b1) begin n_fail++; $display("FAIL full_release_push: got %b exp 1", nice_req_valid); end
        step();
        m0_req_valid = 0; m1_req_valid = 0;
        #1;
        n_checks++; if (ostd_cnt !== 3'd4) begin n_fail++; $display("FAIL full_final_cnt: got %0d exp 4", ostd_cnt); end
    endtask

    task automatic test_lock();
        do_reset();
        m1_req_valid = 1; nice_req_ready = 0;
        #1;
        n_checks++; if (nice_req_instr !== 32'h200) begin n_fail++; $display("FAIL lock_initial: got %h exp 00000200", nice_req_instr); end
        step();
        m0_req_valid = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (nice_req_valid !== 1'b1 || nice_req_instr !== 32'h200 || nice_req_rs2 !== 32'h202) begin n_fail++; $display("FAIL lock_hold%0d: got v=%b instr=%h rs2=%h exp v=1 instr=00000200 rs2=00000202", c, nice_req_valid, nice_req_instr, nice_req_rs2); end
            step();
        end
        nice_req_ready = 1;
        #1;
        n_checks++; if ({m0_req_ready, m1_req_ready} !== 2'b01 || nice_req_instr !== 32'h200) begin n_fail++; $display("FAIL lock_accept: got rdy=%b instr=%h exp rdy=01 instr=00000200", {m0_req_ready, m1_req_ready}, nice_req_instr); end
        step();
        #1;
        n_checks++; if ({m0_req_ready, m1_req_ready} !== 2'b10 || nice_req_instr !== 32'h100) begin n_fail++; $display("FAIL lock_next_grant: got rdy=%b instr=%h exp rdy=10 instr=00000100", {m0_req_ready, m1_req_ready}, nice_req_instr); end
        m0_req_valid = 0; m1_req_valid = 0; nice_req_ready = 0;
        step();
    endtask

    task automatic test_routing();
        do_reset();
        nice_req_ready = 1;
        m1_req_valid = 1; step();
        m1_req_valid = 0; m0_req_valid = 1; step();
        m0_req_valid = 0; nice_req_ready = 0;
        #1;
        n_checks++; if (ostd_cnt !== 3'd2) begin n_fail++; $display("FAIL route_cnt: got %0d exp 2", ostd_cnt); end
        nice_rsp_multicyc_valid = 1; nice_rsp_multicyc_dat = 32'hA5A5_0001; nice_rsp_multicyc_err = 0;
        m1_rsp_ready = 0; m0_rsp_ready = 1;
        #1;
        n_checks++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b01) begin n_fail++; $display("FAIL route_first_valid: got %b exp 01", {m0_rsp_valid, m1_rsp_valid}); end
        n_checks++; if (nice_rsp_multicyc_ready !== 1'b0) begin n_fail++; $display("FAIL route_backpressure: got %b exp 0", nice_rsp_multicyc_ready); end
        n_checks++; if (m_rsp_dat !== 32'hA5A5_0001) begin n_fail++; $display("FAIL route_dat0: got %h exp a5a50001", m_rsp_dat); end
        step();
        #1;
        n_checks++; if (ostd_cnt !== 3'd2 || m1_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL route_head_held: got cnt=%0d v1=%b exp cnt=2 v1=1", ostd_cnt, m1_rsp_valid); end
        m1_rsp_ready = 1;
        #1;
        n_checks++; if (nice_rsp_multicyc_ready !== 1'b1) begin n_fail++; $display("FAIL route_accept1: got %b exp 1", nice_rsp_multicyc_ready); end
        step();
        nice_rsp_multicyc_dat = 32'h0000_5A5A; nice_rsp_multicyc_err = 1; m1_rsp_ready = 0;
        #1;
        n_checks++; if ({m0_rsp_valid, m1_rsp_valid, nice_rsp_multicyc_ready} !== 3'b101) begin n_fail++; $display("FAIL route_second: got %b exp 101", {m0_rsp_valid, m1_rsp_valid, nice_rsp_multicyc_ready}); end
        n_checks++; if (m_rsp_dat !== 32'h0000_5A5A || m_rsp_err !== 1'b1) begin n_fail++; $display("FAIL route_dat1: got %h/%b exp 00005a5a/1", m_rsp_dat, m_rsp_err); end
        step();
        nice_rsp_multicyc_valid = 0; nice_rsp_multicyc_err = 0;
        #1;
        n_checks++; if (ostd_cnt !== 3'd0 || rsp_orphan !== 1'b0) begin n_fail++; $display("FAIL route_drained: got cnt=%0d orphan=%b exp cnt=0 orphan=0", ostd_cnt, rsp_orphan); end
    endtask

    task automatic test_orphan();
        do_reset();
        m0_rsp_ready = 1; m1_rsp_ready = 1;
        nice_rsp_multicyc_valid = 1;
        #1;
        n_checks++; if ({nice_rsp_multicyc_ready, m0_rsp_valid, m1_rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL orphan_no_accept: got %b exp 000", {nice_rsp_multicyc_ready, m0_rsp_valid, m1_rsp_valid}); end
        n_checks++; if (rsp_orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_not_yet: got %b exp 0", rsp_orphan); end
        step();
        nice_rsp_multicyc_valid = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (rsp_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky%0d: got %b exp 1", c, rsp_orphan); end
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_checks++; if (rsp_orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_cleared: got %b exp 0", rsp_orphan); end
    endtask

    // Reset with requests outstanding discards them, so a later response is an orphan.
    task automatic test_reset_midop();
        do_reset();
        nice_req_ready = 1; m0_req_valid = 1;
        step(); step();
        m0_req_valid = 0; nice_req_ready = 0;
        rst = 1'b1; step(); rst = 1'b0;
        nice_rsp_multicyc_valid = 1; m0_rsp_ready = 1;
        #1;
        n_checks++; if (ostd_cnt !== 3'd0 || nice_rsp_multicyc_ready !== 1'b0) begin n_fail++; $display("FAIL midop_discard: got cnt=%0d rdy=%b exp cnt=0 rdy=0", ostd_cnt, nice_rsp_multicyc_ready); end
        step();
        nice_rsp_multicyc_valid = 0;
        #1;
        n_checks++; if (rsp_orphan !== 1'b1) begin n_fail++; $display("FAIL midop_orphan: got %b exp 1", rsp_orphan); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_full();
        test_lock();
        test_routing();
        test_orphan();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
